// File: rtl/wisard_req_arbiter_if.sv
// Handshake bundle between the requesters, the arbiter and the wisard core.
// The slave modport is the arbiter's view; master is the environment (requesters + core).
interface wisard_req_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned INP_W   = 3136,
  parameter int unsigned OUTP_W  = 4
);
  // Requester side
  logic [NUM_REQ-1:0]       req_vld;
  logic [NUM_REQ*INP_W-1:0] req_data;
  logic [NUM_REQ-1:0]       req_rdy;
  // Core side
  logic                     core_inp_vld;
  logic [INP_W-1:0]         core_inp;
  logic                     core_stall;
  logic                     core_outp_vld;
  logic [OUTP_W-1:0]        core_outp;
  // Result return to requesters
  logic [NUM_REQ-1:0]       rsp_vld;
  logic [OUTP_W-1:0]        rsp_class;

  modport master (
    output req_vld, req_data, core_stall, core_outp_vld, core_outp,
    input  req_rdy, core_inp_vld, core_inp, rsp_vld, rsp_class
  );

  modport slave (
    input  req_vld, req_data, core_stall, core_outp_vld, core_outp,
    output req_rdy, core_inp_vld, core_inp, rsp_vld, rsp_class
  );
endinterface

// File: rtl/wisard_req_arbiter.sv
// Round-robin arbiter sharing one wisard core between NUM_REQ sample sources.
// Accepted samples are registered toward the core; requester IDs ride an in-order
// tag FIFO so each core result is routed back to its owner. A RUN/DRAIN/DONE FSM
// lets software quiesce the core.
// Optional: define WISARD_ARB_PERF_EN to add saturating perf_samples and
// perf_stall_cycles counters.
// TAG_DEPTH must be a power of two, at least 2.
module wisard_req_arbiter #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned INP_W     = 3136,
  parameter int unsigned OUTP_W    = 4,
  parameter int unsigned TAG_DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  wisard_req_arbiter_if.slave  bus,
  input  logic                 flush,
  output logic                 flush_done,
  output logic                 tag_err,
  output logic                 busy
`ifdef WISARD_ARB_PERF_EN
  ,
  output logic [31:0]          perf_samples,
  output logic [31:0]          perf_stall_cycles
`endif
);

  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned PtrW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(TAG_DEPTH + 1);

  typedef enum logic [1:0] {StRun, StDrain, StDone} state_e;

  state_e              r_state;
  logic [IdxW-1:0]     r_rr_ptr;
  logic                r_core_inp_vld;
  logic [INP_W-1:0]    r_core_inp;
  logic [IdxW-1:0]     r_tag_mem [TAG_DEPTH];
  logic [PtrW-1:0]     r_wr_ptr;
  logic [PtrW-1:0]     r_rd_ptr;
  logic [CntW-1:0]     r_count;
  logic [NUM_REQ-1:0]  r_rsp_vld;
  logic [OUTP_W-1:0]   r_rsp_class;
  logic                r_tag_err;

  logic                w_drain;
  logic                w_load_ok;
  logic                w_found;
  logic                w_accept;
  logic                w_pop;
  logic                w_miss;
  logic [IdxW:0]       w_cand;
  logic [IdxW-1:0]     w_gnt_idx;
  logic [NUM_REQ-1:0]  w_rdy;
  logic [INP_W-1:0]    w_sel_data;
  logic [IdxW-1:0]     w_head;

  // Load permission: register free (or emptying now), running, tag space left.
  // rst_n gates grants so every output reads 0 while reset is held.
  always_comb begin
    w_drain   = r_core_inp_vld && !bus.core_stall;
    w_load_ok = rst_n && (!r_core_inp_vld || w_drain) && (r_state == StRun) && !flush &&
                (r_count < CntW'(TAG_DEPTH));
  end

  // Round-robin search starting at the pointer, wrapping to lower indices.
  always_comb begin
    w_found   = 1'b0;
    w_gnt_idx = '0;
    w_cand    = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      w_cand = {1'b0, r_rr_ptr} + (IdxW + 1)'(k);
      if (w_cand >= (IdxW + 1)'(NUM_REQ)) begin
        w_cand = w_cand - (IdxW + 1)'(NUM_REQ);
      end
      if (!w_found && bus.req_vld[w_cand[IdxW-1:0]]) begin
        w_found   = 1'b1;
        w_gnt_idx = w_cand[IdxW-1:0];
      end
    end
  end

  // One-hot grant and selected sample data.
  always_comb begin
    w_accept   = w_load_ok && w_found;
    w_rdy      = '0;
    w_sel_data = '0;
    if (w_accept) begin
      w_rdy[w_gnt_idx] = 1'b1;
    end
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (w_gnt_idx == IdxW'(i)) begin
        w_sel_data = bus.req_data[i*INP_W +: INP_W];
      end
    end
  end

  // Result bookkeeping: pop only when a tag exists, otherwise flag the orphan result.
  always_comb begin
    w_pop  = bus.core_outp_vld && (r_count != '0);
    w_miss = bus.core_outp_vld && (r_count == '0);
    w_head = r_tag_mem[r_rd_ptr];
  end

  // Output register toward the core and round-robin pointer advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_core_inp_vld <= 1'b0;
      r_core_inp     <= '0;
      r_rr_ptr       <= '0;
    end else if (w_accept) begin
      r_core_inp_vld <= 1'b1;
      r_core_inp     <= w_sel_data;
      r_rr_ptr       <= (w_gnt_idx == IdxW'(NUM_REQ - 1)) ? '0 : w_gnt_idx + 1'b1;
    end else if (w_drain) begin
      r_core_inp_vld <= 1'b0;
    end
  end

  // Tag storage; contents are meaningless while the count is zero, so no reset.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_tag_mem[r_wr_ptr] <= w_gnt_idx;
    end
  end

  // Tag FIFO pointers and outstanding count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_accept) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      unique case ({w_accept, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Registered response strobe/class and sticky tag error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_vld   <= '0;
      r_rsp_class <= '0;
      r_tag_err   <= 1'b0;
    end else begin
      r_rsp_vld <= '0;
      if (w_pop) begin
        r_rsp_vld[w_head] <= 1'b1;
        r_rsp_class       <= bus.core_outp;
      end
      if (w_miss) begin
        r_tag_err <= 1'b1;
      end
    end
  end

  // Flush FSM: a short flush pulse still runs the drain to completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StRun;
    end else begin
      unique case (r_state)
        StRun:   if (flush) r_state <= StDrain;
        StDrain: if (!r_core_inp_vld && (r_count == '0)) r_state <= StDone;
        StDone:  if (!flush) r_state <= StRun;
        default: r_state <= StRun;
      endcase
    end
  end

`ifdef WISARD_ARB_PERF_EN
  logic [31:0] r_perf_samples;
  logic [31:0] r_perf_stall_cycles;

  // Saturating performance counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_samples      <= '0;
      r_perf_stall_cycles <= '0;
    end else begin
      if (w_accept && (r_perf_samples != '1)) begin
        r_perf_samples <= r_perf_samples + 1'b1;
      end
      if (r_core_inp_vld && bus.core_stall && (r_perf_stall_cycles != '1)) begin
        r_perf_stall_cycles <= r_perf_stall_cycles + 1'b1;
      end
    end
  end

  assign perf_samples      = r_perf_samples;
  assign perf_stall_cycles = r_perf_stall_cycles;
`endif

  assign bus.req_rdy      = w_rdy;
  assign bus.core_inp_vld = r_core_inp_vld;
  assign bus.core_inp     = r_core_inp;
  assign bus.rsp_vld      = r_rsp_vld;
  assign bus.rsp_class    = r_rsp_class;
  assign flush_done       = (r_state == StDone);
  assign tag_err          = r_tag_err;
  assign busy             = (r_count != '0) || r_core_inp_vld;

endmodule

// File: tb/tb_wisard_req_arbiter.sv
// Self-checking bench for wisard_req_arbiter: vector table, directed corner
// sequences and a randomized run against a queue-based reference model.
module tb_wisard_req_arbiter;
  localparam int NR = 4;
  localparam int IW = 32;
  localparam int OW = 4;
  localparam int TD = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic flush_done;
  logic tag_err;
  logic busy;
`ifdef WISARD_ARB_PERF_EN
  logic [31:0] perf_samples;
  logic [31:0] perf_stall_cycles;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  wisard_req_arbiter_if #(.NUM_REQ(NR), .INP_W(IW), .OUTP_W(OW)) bus ();

  wisard_req_arbiter #(
    .NUM_REQ  (NR),
    .INP_W    (IW),
    .OUTP_W   (OW),
    .TAG_DEPTH(TD)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .flush     (flush),
    .flush_done(flush_done),
    .tag_err   (tag_err),
    .busy      (busy)
`ifdef WISARD_ARB_PERF_EN
    ,
    .perf_samples     (perf_samples),
    .perf_stall_cycles(perf_stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] vld;
    logic       stall;
    logic       ovld;
    logic [3:0] ocls;
    logic       fl;
    logic [3:0] e_rdy;
    int         e_inp;   // requester whose data should sit in core_inp, -1 = register empty
    logic [3:0] e_rsp;
    logic [3:0] e_cls;
    logic       e_done;
  } vec_t;

  vec_t tbl[17];

  function automatic vec_t mk(logic [3:0] vld, logic stall, logic ovld, logic [3:0] ocls,
                              logic fl, logic [3:0] e_rdy, int e_inp, logic [3:0] e_rsp,
                              logic [3:0] e_cls, logic e_done);
    vec_t v;
    v.vld = vld; v.stall = stall; v.ovld = ovld; v.ocls = ocls; v.fl = fl;
    v.e_rdy = e_rdy; v.e_inp = e_inp; v.e_rsp = e_rsp; v.e_cls = e_cls; v.e_done = e_done;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] v, input logic st, input logic ov,
                       input logic [3:0] oc, input logic fl);
    bus.req_vld       = v;
    bus.core_stall    = st;
    bus.core_outp_vld = ov;
    bus.core_outp     = oc;
    flush             = fl;
  endtask

  task automatic set_data(input int i, input logic [31:0] val);
    bus.req_data[i*IW +: IW] = val;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(4'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Reference model state
  int          m_q[$];
  bit          m_vld;
  logic [31:0] m_data;
  int          m_ptr;
  int          m_state;   // 0 run, 1 drain, 2 done
  bit          m_err;
  int          m_rsp;
  logic [3:0]  m_cls;
  logic [31:0] rd[NR];

  initial begin
    #1000000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int pre_size;
    bit pre_vld;
    bit found;
    bit load_ok;
    int g;
    int idx;
    int h;
    int flush_left;
    logic [3:0] vld;
    logic st;
    logic ov;
    logic [3:0] oc;
    logic [31:0] hold;

    bus.req_data = '0;
    do_reset();

    // ---------------- reset state ----------------
    chk("rst core_inp_vld", bus.core_inp_vld, 0);
    chk("rst core_inp", bus.core_inp, 0);
    chk("rst rsp_vld", bus.rsp_vld, 0);
    chk("rst rsp_class", bus.rsp_class, 0);
    chk("rst flush_done", flush_done, 0);
    chk("rst tag_err", tag_err, 0);
    chk("rst busy", busy, 0);
    chk("rst req_rdy", bus.req_rdy, 0);

    // ---------------- vector table ----------------
    tbl[0]  = mk(4'b1111, 0, 0, 0, 0, 4'b0001,  0, 4'b0000, 0, 0);
    tbl[1]  = mk(4'b1111, 0, 0, 0, 0, 4'b0010,  1, 4'b0000, 0, 0);
    tbl[2]  = mk(4'b1111, 0, 0, 0, 0, 4'b0100,  2, 4'b0000, 0, 0);
    tbl[3]  = mk(4'b1111, 0, 0, 0, 0, 4'b1000,  3, 4'b0000, 0, 0);
    tbl[4]  = mk(4'b0000, 0, 1, 5, 0, 4'b0000, -1, 4'b0001, 5, 0);
    tbl[5]  = mk(4'b0000, 0, 1, 6, 0, 4'b0000, -1, 4'b0010, 6, 0);
    tbl[6]  = mk(4'b0000, 0, 1, 7, 0, 4'b0000, -1, 4'b0100, 7, 0);
    tbl[7]  = mk(4'b0000, 0, 1, 8, 0, 4'b0000, -1, 4'b1000, 8, 0);
    tbl[8]  = mk(4'b1010, 0, 0, 0, 0, 4'b0010,  1, 4'b0000, 0, 0);
    tbl[9]  = mk(4'b1010, 0, 0, 0, 1, 4'b0000, -1, 4'b0000, 0, 0);
    tbl[10] = mk(4'b1010, 0, 0, 0, 0, 4'b0000, -1, 4'b0000, 0, 0);
    tbl[11] = mk(4'b1010, 0, 1, 2, 0, 4'b0000, -1, 4'b0010, 2, 0);
    tbl[12] = mk(4'b1010, 0, 0, 0, 0, 4'b0000, -1, 4'b0000, 0, 1);
    tbl[13] = mk(4'b1010, 0, 0, 0, 0, 4'b0000, -1, 4'b0000, 0, 0);
    tbl[14] = mk(4'b1010, 0, 0, 0, 0, 4'b1000,  3, 4'b0000, 0, 0);
    tbl[15] = mk(4'b1010, 1, 0, 0, 0, 4'b0000,  3, 4'b0000, 0, 0);
    tbl[16] = mk(4'b0000, 0, 0, 0, 0, 4'b0000, -1, 4'b0000, 0, 0);
    for (int i = 0; i < NR; i++) set_data(i, 32'hA0 + i);
    for (int i = 0; i < 17; i++) begin
      drive(tbl[i].vld, tbl[i].stall, tbl[i].ovld, tbl[i].ocls, tbl[i].fl);
      #1;
      chk($sformatf("tbl%0d req_rdy", i), bus.req_rdy, tbl[i].e_rdy);
      tick();
      chk($sformatf("tbl%0d core_inp_vld", i), bus.core_inp_vld, (tbl[i].e_inp >= 0) ? 1 : 0);
      if (tbl[i].e_inp >= 0) begin
        chk($sformatf("tbl%0d core_inp", i), bus.core_inp, 32'hA0 + tbl[i].e_inp);
      end
      chk($sformatf("tbl%0d rsp_vld", i), bus.rsp_vld, tbl[i].e_rsp);
      if (tbl[i].e_rsp != 0) begin
        chk($sformatf("tbl%0d rsp_class", i), bus.rsp_class, tbl[i].e_cls);
      end
      chk($sformatf("tbl%0d flush_done", i), flush_done, tbl[i].e_done);
    end

    // ---------------- single requester ----------------
    do_reset();
    set_data(0, 32'h12345678);
    drive(4'b0001, 0, 0, 0, 0);
    #1;
    chk("single req_rdy", bus.req_rdy, 4'b0001);
    tick();
    chk("single core_inp_vld", bus.core_inp_vld, 1);
    chk("single core_inp", bus.core_inp, 32'h12345678);
    drive(4'b0000, 0, 1, 4'd3, 0);
    tick();
    chk("single rsp_vld", bus.rsp_vld, 4'b0001);
    chk("single rsp_class", bus.rsp_class, 3);
    drive(4'b0000, 0, 0, 0, 0);
    tick();
    chk("single rsp_vld drop", bus.rsp_vld, 0);
    chk("single busy idle", busy, 0);

    // ---------------- stall hold ----------------
    do_reset();
    set_data(0, 32'hDEADBEEF);
    drive(4'b0001, 1, 0, 0, 0);
    tick();
    chk("stall load", bus.core_inp, 32'hDEADBEEF);
    drive(4'b1111, 1, 0, 0, 0);
    for (int c = 0; c < 5; c++) begin
      #1;
      chk($sformatf("stall%0d req_rdy", c), bus.req_rdy, 0);
      tick();
      chk($sformatf("stall%0d core_inp_vld", c), bus.core_inp_vld, 1);
      chk($sformatf("stall%0d core_inp", c), bus.core_inp, 32'hDEADBEEF);
    end
    drive(4'b0000, 0, 0, 0, 0);
    tick();
    chk("stall consumed", bus.core_inp_vld, 0);

    // ---------------- tag FIFO full ----------------
    do_reset();
    drive(4'b1111, 0, 0, 0, 0);
    acc = 0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (bus.req_rdy != 0) acc++;
      tick();
    end
    chk("full accepts", acc, 8);
    chk("full req_rdy", bus.req_rdy, 0);
    chk("full busy", busy, 1);
    drive(4'b1111, 0, 1, 4'd1, 0);
    tick();
    chk("full pop rsp_vld", bus.rsp_vld, 4'b0001);
    drive(4'b1111, 0, 0, 0, 0);
    acc = 0;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (bus.req_rdy != 0) acc++;
      tick();
    end
    chk("full one more", acc, 1);

    // ---------------- tag error ----------------
    do_reset();
    chk("tagerr initial", tag_err, 0);
    drive(4'b0000, 0, 1, 4'd9, 0);
    tick();
    chk("tagerr set", tag_err, 1);
    chk("tagerr rsp_vld", bus.rsp_vld, 0);
    drive(4'b0000, 0, 0, 0, 0);
    repeat (3) tick();
    chk("tagerr sticky", tag_err, 1);
    chk("tagerr busy", busy, 0);

    // ---------------- reset mid-traffic ----------------
    do_reset();
    drive(4'b1111, 1, 0, 0, 0);
    repeat (3) tick();
    chk("midrst busy before", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst req_rdy", bus.req_rdy, 0);
    chk("midrst core_inp_vld", bus.core_inp_vld, 0);
    chk("midrst core_inp", bus.core_inp, 0);
    chk("midrst busy", busy, 0);
    chk("midrst flush_done", flush_done, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(4'b0000, 0, 1, 4'd4, 0);
    tick();
    chk("midrst late result tag_err", tag_err, 1);
    chk("midrst late result rsp_vld", bus.rsp_vld, 0);

    // ---------------- randomized vs model ----------------
    do_reset();
    m_q.delete();
    m_vld = 0; m_data = '0; m_ptr = 0; m_state = 0; m_err = 0; m_rsp = 0; m_cls = '0;
    flush_left = 0;
    for (int c = 0; c < 3000; c++) begin
      vld = 4'($urandom_range(0, 15));
      st  = ($urandom_range(0, 3) == 0);
      if (m_q.size() > 0) ov = ($urandom_range(0, 2) == 0);
      else ov = ($urandom_range(0, 49) == 0);
      oc = 4'($urandom_range(0, 15));
      if (flush_left > 0) begin
        flush_left--;
        flush = 1'b1;
      end else begin
        flush = 1'b0;
        if ($urandom_range(0, 59) == 0) flush_left = $urandom_range(1, 6);
      end
      for (int i = 0; i < NR; i++) begin
        rd[i] = $urandom;
        set_data(i, rd[i]);
      end
      drive(vld, st, ov, oc, flush);
      #1;
      load_ok = (!m_vld || !st) && (m_state == 0) && !flush && (m_q.size() < TD);
      found = 0;
      g = 0;
      for (int k = 0; k < NR; k++) begin
        idx = (m_ptr + k) % NR;
        if (!found && vld[idx]) begin
          found = 1;
          g = idx;
        end
      end
      chk($sformatf("rnd%0d req_rdy", c), bus.req_rdy, (found && load_ok) ? (1 << g) : 0);
      tick();
      pre_size = m_q.size();
      pre_vld  = m_vld;
      m_rsp = 0;
      if (ov) begin
        if (pre_size > 0) begin
          h = m_q.pop_front();
          m_rsp = 1 << h;
          m_cls = oc;
        end else begin
          m_err = 1;
        end
      end
      if (found && load_ok) begin
        m_q.push_back(g);
        m_vld  = 1;
        m_data = rd[g];
        m_ptr  = (g + 1) % NR;
      end else if (m_vld && !st) begin
        m_vld = 0;
      end
      case (m_state)
        0: if (flush) m_state = 1;
        1: if (!pre_vld && pre_size == 0) m_state = 2;
        default: if (!flush) m_state = 0;
      endcase
      chk($sformatf("rnd%0d core_inp_vld", c), bus.core_inp_vld, m_vld);
      if (m_vld) chk($sformatf("rnd%0d core_inp", c), bus.core_inp, m_data);
      chk($sformatf("rnd%0d rsp_vld", c), bus.rsp_vld, m_rsp);
      if (m_rsp != 0) chk($sformatf("rnd%0d rsp_class", c), bus.rsp_class, m_cls);
      chk($sformatf("rnd%0d flush_done", c), flush_done, (m_state == 2));
      chk($sformatf("rnd%0d tag_err", c), tag_err, m_err);
      chk($sformatf("rnd%0d busy", c), busy, (m_q.size() != 0) || m_vld);
    end

    hold = 32'(n_checks);
    $display("TB_RESULT checks=%0d failures=%0d", hold, n_fail);
    $finish;
  end

endmodule

// File: doc/wisard_req_arbiter.md
Name: wisard_req_arbiter

Overview:
- Shares one `wisard` inference core between NUM_REQ independent sample sources.
- Round-robin grants one requester's sample into the core's inp_vld/stall interface and registers it.
- Tracks each in-flight sample's requester ID in an in-order tag FIFO and routes each core result back to the owning requester.
- Provides a flush/drain FSM so software can quiesce the core.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- INP_W, 3136, sample width (bits per requester data bus).
- OUTP_W, 4, class-index width returned by the core.
- TAG_DEPTH, 8, maximum samples in flight (power of 2).

Ports:
- clk  in  1  clock, all logic rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- req_vld  in  NUM_REQ  per-requester sample valid.
- req_data  in  NUM_REQ*INP_W  requester i occupies bits [i*INP_W +: INP_W].
- req_rdy  out  NUM_REQ  one-hot grant; sample i is accepted when req_vld[i] && req_rdy[i].
- core_inp_vld  out  1  registered valid to core.
- core_inp  out  INP_W  registered sample to core.
- core_stall  in  1  core backpressure; core consumes on an edge where core_inp_vld && !core_stall.
- core_outp_vld  in  1  core result valid (single cycle, in issue order).
- core_outp  in  OUTP_W  core class result.
- rsp_vld  out  NUM_REQ  one-hot result strobe, registered.
- rsp_class  out  OUTP_W  result class, registered.
- flush  in  1  level request to stop granting and drain.
- flush_done  out  1  high while in DONE state.
- tag_err  out  1  sticky; result arrived with tag FIFO empty.
- busy  out  1  outstanding count != 0 or core_inp_vld.

Behaviour:
- Reset values: all outputs 0; RR pointer = 0; tag FIFO empty; FSM = RUN.
- Output register:
  - Empty when core_inp_vld=0.
  - Drained on an edge with core_inp_vld && !core_stall.
  - Load permitted when (register empty or draining this cycle) && FSM==RUN && outstanding < TAG_DEPTH.
- Grant:
  - req_rdy is combinational from req_vld, the RR pointer and the load permission; at most one bit set.
  - Search starts at the pointer, lowest index first after wrapping.
  - On accept of requester g: core_inp <= req_data[g], core_inp_vld <= 1, push g into the tag FIFO, pointer <= (g+1) mod NUM_REQ.
- While core_inp_vld && core_stall: core_inp and core_inp_vld hold stable; no grant.
- Throughput: 1 sample/cycle with no stall. Latency from req accept to core_inp_vld is 1 cycle.
- Outstanding count:
  - Increments on push, decrements on pop.
  - Simultaneous push and pop leaves it unchanged.
  - Push is never issued when the count equals TAG_DEPTH.
- Result path:
  - core_outp_vld pops the FIFO head h.
  - Next cycle: rsp_vld = one-hot(h), rsp_class = core_outp. rsp_vld drops after one cycle.
  - If core_outp_vld arrives with the FIFO empty: set tag_err (sticky until reset), no rsp_vld, count stays 0.
- Flush FSM (RUN, DRAIN, DONE):
  - RUN -> DRAIN when flush=1. Grants stop in the same cycle.
  - DRAIN -> DONE when core_inp_vld=0 and outstanding=0.
  - DONE -> RUN when flush=0.
  - flush pulsed shorter than the drain still completes the drain. DONE is entered and is left the cycle after entry if flush is already low.
  - In DRAIN, a sample already held in the output register still presents to the core.
- Reset mid-operation: all state cleared asynchronously; in-flight results arriving after reset set tag_err. Integration must reset the core with the same reset.

Optional Feature:
- Macro: WISARD_ARB_PERF_EN.
- Defined: adds outputs perf_samples (32 bits, total accepted samples) and perf_stall_cycles (32 bits, cycles with core_inp_vld && core_stall). Both saturate at all-ones and are cleared by reset.
- Undefined: these ports and their counters are absent; all other behaviour is identical.

Test Plan:
- Single requester: req_vld=0001, core_stall=0, data=12345678 -> core_inp=12345678, core_inp_vld high 1 cycle after accept. Core returns class 3 -> rsp_vld=0001, rsp_class=3 one cycle later.
- All four requesting continuously, no stall -> grant order 0,1,2,3,0,1,...; results 5,6,7,8 return in order -> rsp_vld 0001,0010,0100,1000 with matching classes.
- core_stall held 5 cycles with a sample loaded -> core_inp stable, req_rdy=0 throughout; sample consumed on the first edge after stall falls.
- Core never returns results, requesters always valid -> exactly 8 accepts, then req_rdy=0. One result -> exactly one more accept.
- 3 samples in flight, pulse flush for 1 cycle -> no new grants. flush_done rises the cycle after the 3rd result pops and stays high 1 cycle, then grants resume.
- core_outp_vld with FIFO empty -> tag_err=1 and stays set, rsp_vld stays 0. Assert rst_n low mid-traffic -> all outputs 0 immediately.
